mux4_scan_ctrl: RTL and testbench
=================================

Name: mux4_scan_ctrl

Overview:
- Round-robin scan controller wrapped around a behavioural 4:1 mux (inputs a/b/c/d, selects s0/s1, output out).
- Drives the mux select lines s0/s1 to step through channels 0..3. Holds each channel for DWELL cycles and samples the mux output after SETTLE cycles.
- Assembles the four samples into a 4-bit frame and publishes it with a one-cycle valid strobe.
- Sits directly upstream of the mux (select driver) and consumes its output.

Parameters:
- DWELL, 4: cycles each channel is held selected; legal range 2..255.
- SETTLE, 1: cycles after a select change before mux_out is sampled; legal range 1..DWELL-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable (level)
- mux_out  input  1  output of the 4:1 mux under control
- s0  output  1  mux select MSB
- s1  output  1  mux select LSB
- sample  output  4  last complete frame; bit i = channel i (0=a, 1=b, 2=c, 3=d)
- frame_valid  output  1  one-cycle strobe, sample updated this cycle
- busy  output  1  high while in SCAN

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: s0=0, s1=0, sample=4'b0000, frame_valid=0, busy=0, state=IDLE, ch=0, cnt=0, shadow=0.
- Channel encoding: ch index = {s0,s1}, so s0 is the MSB. 00 selects a, 01 b, 10 c, 11 d.
- s0/s1 are driven straight from the ch register, with no combinational path from en.
- State IDLE:
  - ch=0, cnt=0, busy=0.
  - On a clock edge with en=1: go to SCAN with ch=0, cnt=0.
- State SCAN:
  - busy=1.
  - cnt increments every cycle, 0..DWELL-1.
  - At the edge where cnt==SETTLE: shadow[ch] <= mux_out.
  - At the edge where cnt==DWELL-1: cnt<=0. If ch<3, ch<=ch+1.
  - At the edge where cnt==DWELL-1 and ch==3:
    - sample <= shadow, with bit 3 already captured because SETTLE<DWELL-1 or SETTLE==DWELL-1 is handled by forwarding mux_out into bit 3 when SETTLE==DWELL-1.
    - frame_valid <= 1 for exactly one cycle.
    - ch <= 0.
    - If en==1, stay in SCAN; otherwise go to IDLE.
- Latency: the first frame_valid is high in the cycle after edge E0+4*DWELL, where E0 is the edge that samples en=1 in IDLE.
- Frame period under continuous en: 4*DWELL cycles, with back-to-back frames and no gap cycle.
- en deasserted mid-frame: the current frame completes and is published, then the block returns to IDLE. Partial frames are never published.
- en reasserted in the same cycle as the final frame edge: scanning continues with no IDLE cycle.
- sample holds its value between frames and while in IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial shadow is discarded.
- Counter widths: cnt is 8 bits; ch is 2 bits with natural wrap from 3 to 0.

Optional Feature:
- Macro: MUX4_SCAN_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit), equal to the XOR of the four bits of sample.
  - parity is registered and updated on the same edge as sample. Reset value is 0.
- When undefined: the parity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mux4_scan_pkg holds:
  - state encoding: IDLE=1'b0, SCAN=1'b1
  - channel constants: CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3
  - counter width constant CNT_W=8
- One natural sub-module: mux4_dwell_cnt.
  - Parameter DWELL.
  - Ports: clk, rst_n, run, cnt, last.
  - last is high when cnt==DWELL-1.
- The top level holds the FSM, channel register, shadow, and output registers.

Test Plan (DWELL=4, SETTLE=1, testbench instantiates the 4:1 mux driven by s0/s1):
- a=1, b=c=d=0, en=1 held:
  - s0s1 sequence 00,01,10,11, each for 4 cycles.
  - frame_valid is high one cycle after edge E0+16, with sample=4'b0001.
  - It repeats every 16 cycles.
- a=0, b=1, c=1, d=0, en pulsed high for one cycle:
  - Exactly one frame with sample=4'b0110.
  - busy is high for 16 cycles, then the block is in IDLE with s0s1=00.
- en dropped at cycle 6 of a frame:
  - The frame still completes and frame_valid fires once.
  - No second frame; busy=0 afterward.
- rst_n pulled low at cycle 9 of the first frame (d=1):
  - All outputs return to reset values asynchronously, before the next clk edge.
  - sample stays 4'b0000.
  - After release with en=1, the first frame has sample=4'b1000.
- Input change inside the dwell window: b toggles 0->1 at cnt=2 of channel 1 (after the SETTLE sample).
  - sample[1]=0 for that frame and 1 for the next frame.
- With MUX4_SCAN_PARITY_EN and a=b=d=1, c=0:
  - sample=4'b1011 and parity=1.
  - With a=b=1, c=d=0: parity=0.

Source files
------------

// File: rtl/mux4_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux4_scan_pkg
// Shared definitions for the 4:1 mux scan controller:
//   - state_t  : FSM state encoding (IDLE / SCAN)
//   - CH_A..D  : channel indices, channel = {s0,s1}
//   - CNT_W    : dwell counter width
//   - parity4  : even-parity helper over a 4-bit frame
// -----------------------------------------------------------------------------
package mux4_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam int CNT_W = 8;

  // XOR of all four frame bits
  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mux4_dwell_cnt.sv
// -----------------------------------------------------------------------------
// mux4_dwell_cnt
// Per-channel dwell counter. Counts 0..DWELL-1 while run is high and wraps;
// held at zero while run is low.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   run   in   count enable (high while scanning)
//   cnt   out  current dwell count (CNT_W bits)
//   last  out  high when cnt == DWELL-1
// -----------------------------------------------------------------------------
module mux4_dwell_cnt
  import mux4_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_r;

  // Decode of the terminal count
  assign last = (cnt_r == LAST_V);
  assign cnt  = cnt_r;

  // Dwell counter register: clears when idle, wraps at DWELL-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!run) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (last) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux4_scan_ctrl
// Round-robin scan controller for a 4:1 mux. Steps the select lines through
// channels 0..3, holding each for DWELL cycles and sampling mux_out SETTLE
// cycles after the select change. The four samples are published as one
// frame with a single-cycle frame_valid strobe.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable (level)
//   mux_out     in   output of the controlled mux
//   s0          out  select MSB (ch[1])
//   s1          out  select LSB (ch[0])
//   sample      out  last complete frame, bit i = channel i
//   frame_valid out  one-cycle strobe, sample updated this cycle
//   busy        out  high while scanning
//   parity      out  XOR of sample bits (only with MUX4_SCAN_PARITY_EN)
// Optional feature macro: MUX4_SCAN_PARITY_EN
// -----------------------------------------------------------------------------
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] sample,
  output logic       frame_valid,
`ifdef MUX4_SCAN_PARITY_EN
  output logic       busy,
  output logic       parity
`else
  output logic       busy
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

  state_t           state_r, state_next_s;
  logic [1:0]       ch_r, ch_next_s;
  logic [3:0]       shadow_r, shadow_next_s;
  logic [3:0]       sample_r, sample_next_s;
  logic             frame_valid_r, frame_valid_next_s;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_s;
  logic             last_s;
  logic             run_s;

  assign run_s = (state_r == SCAN);

  mux4_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .cnt   (cnt_s),
    .last  (last_s)
  );

  // Next-state and next-value logic for the scan FSM and its datapath
  always_comb begin
    state_next_s       = state_r;
    ch_next_s          = ch_r;
    shadow_next_s      = shadow_r;
    sample_next_s      = sample_r;
    frame_valid_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        ch_next_s = CH_A;
        if (en) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (cnt_s == SETTLE_V) begin
          shadow_next_s[ch_r] = mux_out;
        end else begin
          shadow_next_s = shadow_r;
        end
        if (last_s) begin
          // Natural 2-bit wrap takes channel D back to A
          ch_next_s = ch_r + 2'd1;
          if (ch_r == CH_D) begin
            // Publish from shadow_next_s so that a capture on this very
            // edge (SETTLE == DWELL-1) is forwarded into bit 3
            sample_next_s      = shadow_next_s;
            frame_valid_next_s = 1'b1;
            if (en) begin
              state_next_s = SCAN;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            state_next_s = SCAN;
          end
        end else begin
          state_next_s = SCAN;
        end
      end
      default: begin
        state_next_s = IDLE;
        ch_next_s    = CH_A;
      end
    endcase
  end

  // State, channel, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      ch_r          <= CH_A;
      shadow_r      <= 4'b0000;
      sample_r      <= 4'b0000;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      ch_r          <= ch_next_s;
      shadow_r      <= shadow_next_s;
      sample_r      <= sample_next_s;
      frame_valid_r <= frame_valid_next_s;
      busy_r        <= (state_next_s == SCAN);
    end
  end

`ifdef MUX4_SCAN_PARITY_EN
  logic parity_r;

  // Frame parity, updated on the same edge as sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity4(sample_next_s);
    end
  end

  assign parity = parity_r;
`endif

  // Selects come straight from the channel register
  assign s0          = ch_r[1];
  assign s1          = ch_r[0];
  assign sample      = sample_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux4_scan_ctrl
// Self-checking bench for mux4_scan_ctrl (DWELL=4, SETTLE=1) with a
// behavioural 4:1 mux closing the loop from s0/s1 back to mux_out.
// -----------------------------------------------------------------------------
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a, b, c, d;
  logic       mux_out;
  logic       s0, s1;
  logic [3:0] sample;
  logic       frame_valid;
  logic       busy;
`ifdef MUX4_SCAN_PARITY_EN
  logic       parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux, s0 is the MSB
  always_comb begin
    mux_out = 1'b0;
    case ({s0, s1})
      2'd0:    mux_out = a;
      2'd1:    mux_out = b;
      2'd2:    mux_out = c;
      2'd3:    mux_out = d;
      default: mux_out = 1'b0;
    endcase
  end

  mux4_scan_ctrl #(
    .DWELL  (4),
    .SETTLE (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mux_out     (mux_out),
    .s0          (s0),
    .s1          (s1),
    .sample      (sample),
    .frame_valid (frame_valid),
`ifdef MUX4_SCAN_PARITY_EN
    .busy        (busy),
    .parity      (parity)
`else
    .busy        (busy)
`endif
  );

  typedef struct {
    logic [3:0] inp;    // {d,c,b,a}
    int         hold;   // negedges after E0 with en still high
    logic [3:0] exp_s;
    logic       exp_p;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_sel"}, {30'd0, s0, s1}, 32'd0);
    chk({nm, "_sample"}, {28'd0, sample}, 32'd0);
    chk({nm, "_fv"}, {31'd0, frame_valid}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef MUX4_SCAN_PARITY_EN
    chk({nm, "_parity"}, {31'd0, parity}, 32'd0);
`endif
  endtask

  // Waits (bounded) until the block is idle again
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // One frame started from IDLE with en held for 'hold' negedges after E0
  task automatic frame_run(input string nm, input vec_t v);
    int hit_n, nfv, nbusy;
    @(negedge clk);
    set_in(v.inp);
    en = 1'b1;
    @(negedge clk);                 // E0 has just sampled en=1
    nbusy = busy ? 1 : 0;
    hit_n = -1;
    nfv   = 0;
    if (v.hold == 0) en = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == v.hold) en = 1'b0;
      if (busy) nbusy++;
      if (frame_valid) begin
        nfv++;
        if (hit_n < 0) begin
          hit_n = n;
          chk({nm, "_sample"}, {28'd0, sample}, {28'd0, v.exp_s});
`ifdef MUX4_SCAN_PARITY_EN
          chk({nm, "_parity"}, {31'd0, parity}, {31'd0, v.exp_p});
`endif
        end
      end
    end
    chk({nm, "_latency"}, hit_n, 32'd16);
    chk({nm, "_nframes"}, nfv, 32'd1);
    chk({nm, "_busycycles"}, nbusy, 32'd16);
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_sel_after"}, {30'd0, s0, s1}, 32'd0);
    chk({nm, "_hold_sample"}, {28'd0, sample}, {28'd0, v.exp_s});
  endtask

  initial begin
    vecs[0] = '{inp: 4'b0001, hold: 0, exp_s: 4'b0001, exp_p: 1'b1};
    vecs[1] = '{inp: 4'b0110, hold: 0, exp_s: 4'b0110, exp_p: 1'b0};
    vecs[2] = '{inp: 4'b1011, hold: 5, exp_s: 4'b1011, exp_p: 1'b1};
    vecs[3] = '{inp: 4'b0011, hold: 0, exp_s: 4'b0011, exp_p: 1'b0};
    vecs[4] = '{inp: 4'b0000, hold: 5, exp_s: 4'b0000, exp_p: 1'b0};
    vecs[5] = '{inp: 4'b1111, hold: 3, exp_s: 4'b1111, exp_p: 1'b0};
    vecs[6] = '{inp: 4'b0100, hold: 0, exp_s: 4'b0100, exp_p: 1'b1};

    rst_n = 1'b0;
    en    = 1'b0;
    set_in(4'b0000);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_en_busy", {31'd0, busy}, 32'd0);

    // Continuous scan: select sequence and back-to-back frames every 16 cycles
    set_in(4'b0001);
    en = 1'b1;
    @(negedge clk);                 // after E0, j = 0
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("cont_sel_%0d", j), {30'd0, s0, s1}, (j / 4) % 4);
      if (j == 16 || j == 32) begin
        chk($sformatf("cont_fv_%0d", j), {31'd0, frame_valid}, 32'd1);
        chk($sformatf("cont_sample_%0d", j), {28'd0, sample}, 32'h1);
      end else begin
        chk($sformatf("cont_fv_%0d", j), {31'd0, frame_valid}, 32'd0);
      end
      if (j > 0) chk($sformatf("cont_busy_%0d", j), {31'd0, busy}, 32'd1);
    end
    en = 1'b0;
    wait_idle("cont");

    // Table of single frames, en pulsed or dropped mid-frame
    for (int i = 0; i < 7; i++) begin
      frame_run($sformatf("vec%0d", i), vecs[i]);
    end

    // b rises after channel 1 was sampled: old value in frame 1, new in frame 2
    @(negedge clk);
    set_in(4'b0000);
    en = 1'b1;
    @(negedge clk);                 // after E0
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if (j == 6) b = 1'b1;         // cnt == 2 on channel 1
      if (j == 16) begin
        chk("tog_fv1", {31'd0, frame_valid}, 32'd1);
        chk("tog_sample1", {28'd0, sample}, 32'h0);
        en = 1'b0;
      end
      if (j == 32) begin
        chk("tog_fv2", {31'd0, frame_valid}, 32'd1);
        chk("tog_sample2", {28'd0, sample}, 32'h2);
      end
    end
    wait_idle("tog");

    // Reset mid-frame: asynchronous clear, partial frame discarded
    @(negedge clk);
    set_in(4'b1000);
    en = 1'b1;
    @(negedge clk);                 // after E0
    repeat (9) @(negedge clk);
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    chk("rst_sel_before", {30'd0, s0, s1}, 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);                 // after E0 following release
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) en = 1'b0;
      if (j == 15) begin
        chk("rst_sample_hold", {28'd0, sample}, 32'h0);
        chk("rst_fv_early", {31'd0, frame_valid}, 32'd0);
      end
      if (j == 16) begin
        chk("rst_fv", {31'd0, frame_valid}, 32'd1);
        chk("rst_sample", {28'd0, sample}, 32'h8);
`ifdef MUX4_SCAN_PARITY_EN
        chk("rst_parity", {31'd0, parity}, 32'd1);
`endif
      end
    end
    wait_idle("rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
